// File: rtl/dh_exchange_sequencer_if.sv
// Engine port bundle: the sequencer (master) launches modexp jobs, the engine (slave) answers.
// Operands are held by the master from launch until eng_done; eng_busy stalls the launch.
interface dh_exchange_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             eng_start;
    logic [WIDTH-1:0] eng_base;
    logic [WIDTH-1:0] eng_exp;
    logic [WIDTH-1:0] eng_mod;
    logic             eng_busy;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;

    modport master (
        output eng_start, eng_base, eng_exp, eng_mod,
        input  eng_busy, eng_done, eng_result
    );

    modport slave (
        input  eng_start, eng_base, eng_exp, eng_mod,
        output eng_busy, eng_done, eng_result
    );
endinterface

// File: rtl/dh_exchange_sequencer.sv
// DH job sequencer: one modexp engine shared round-robin by Alice/Bob (PUB then KEY jobs); `ENGINE_TIMEOUT_EN adds a WAIT watchdog.
// Latency req->eng_start 3 edges, result 1 edge after eng_done; stalls in ISSUE while eng_busy, repeat requests absorbed.
module dh_exchange_sequencer #(
    parameter int WIDTH       = 8,
    parameter int GEN         = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p_load,
    input  logic [WIDTH-1:0]        p_in,
    input  logic                    req_a,
    input  logic                    req_b,
    input  logic [WIDTH-1:0]        sec_a,
    input  logic [WIDTH-1:0]        sec_b,
    dh_exchange_sequencer_if.master eng,
    output logic [WIDTH-1:0]        pub_a,
    output logic [WIDTH-1:0]        pub_b,
    output logic [WIDTH-1:0]        key_a,
    output logic [WIDTH-1:0]        key_b,
    output logic                    pub_a_vld,
    output logic                    pub_b_vld,
    output logic                    key_a_vld,
    output logic                    key_b_vld,
    output logic                    rej,
    output logic                    p_err,
    output logic                    timeout,
    output logic [3:0]              state_o
);
    localparam logic [WIDTH-1:0] GEN_W = WIDTH'(GEN);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ISSUE = 4'd1,
        ST_WAIT  = 4'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] exp_q;
    logic             pend_a;
    logic             pend_b;
    logic             prio_b;
    logic             tgt_key;
    logic             tgt_b;
    logic             start_q;

    logic             any_pend;
    logic             both_pend;
    logic             grant_b;
    logic             own_pub_vld;
    logic             peer_pub_vld;
    logic             own_key_vld;
    logic [WIDTH-1:0] own_sec;
    logic [WIDTH-1:0] peer_pub;
    logic             do_pub;
    logic             do_key;

    // Job selection for whichever requester wins this IDLE slot.
    always_comb begin
        any_pend     = pend_a | pend_b;
        both_pend    = pend_a & pend_b;
        grant_b      = pend_b & (~pend_a | prio_b);
        own_pub_vld  = grant_b ? pub_b_vld : pub_a_vld;
        peer_pub_vld = grant_b ? pub_a_vld : pub_b_vld;
        own_key_vld  = grant_b ? key_b_vld : key_a_vld;
        own_sec      = grant_b ? sec_b : sec_a;
        peer_pub     = grant_b ? pub_a : pub_b;
        do_pub       = ~p_err & ~own_pub_vld;
        do_key       = ~p_err & own_pub_vld & peer_pub_vld & ~own_key_vld;
    end

    assign eng.eng_start = start_q;
    assign eng.eng_base  = base_q;
    assign eng.eng_exp   = exp_q;
    assign eng.eng_mod   = p;
    assign state_o       = state;

    // A non-positive limit would make the watchdog fire on entry.
    if (TIMEOUT_CYC < 1) begin : g_timeout_cyc_must_be_positive
    end

`ifdef ENGINE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wd_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            p         <= '0;
            p_err     <= 1'b1;
            pend_a    <= 1'b0;
            pend_b    <= 1'b0;
            prio_b    <= 1'b0;
            tgt_key   <= 1'b0;
            tgt_b     <= 1'b0;
            base_q    <= '0;
            exp_q     <= '0;
            start_q   <= 1'b0;
            rej       <= 1'b0;
            pub_a     <= '0;
            pub_b     <= '0;
            key_a     <= '0;
            key_b     <= '0;
            pub_a_vld <= 1'b0;
            pub_b_vld <= 1'b0;
            key_a_vld <= 1'b0;
            key_b_vld <= 1'b0;
`ifdef ENGINE_TIMEOUT_EN
            timeout   <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            rej     <= 1'b0;

            // A p_load swallows any request arriving with it.
            if (!p_load) begin
                if (req_a) pend_a <= 1'b1;
                if (req_b) pend_b <= 1'b1;
            end

            if (p_load && state != ST_IDLE) rej <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (p_load) begin
                        p         <= p_in;
                        p_err     <= (p_in < WIDTH'(2));
                        pend_a    <= 1'b0;
                        pend_b    <= 1'b0;
                        pub_a_vld <= 1'b0;
                        pub_b_vld <= 1'b0;
                        key_a_vld <= 1'b0;
                        key_b_vld <= 1'b0;
`ifdef ENGINE_TIMEOUT_EN
                        timeout   <= 1'b0;
`endif
                    end else if (any_pend) begin
                        if (grant_b) pend_b <= 1'b0;
                        else         pend_a <= 1'b0;
                        if (both_pend) prio_b <= ~prio_b;
                        if (do_pub || do_key) begin
                            base_q  <= do_pub ? GEN_W : peer_pub;
                            exp_q   <= own_sec;
                            tgt_key <= do_key;
                            tgt_b   <= grant_b;
                            state   <= ST_ISSUE;
                        end else begin
                            rej <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (!eng.eng_busy) begin
                        start_q <= 1'b1;
                        state   <= ST_WAIT;
`ifdef ENGINE_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end

                ST_WAIT: begin
                    if (eng.eng_done) begin
                        case ({tgt_key, tgt_b})
                            2'b00: begin pub_a <= eng.eng_result; pub_a_vld <= 1'b1; end
                            2'b01: begin pub_b <= eng.eng_result; pub_b_vld <= 1'b1; end
                            2'b10: begin key_a <= eng.eng_result; key_a_vld <= 1'b1; end
                            2'b11: begin key_b <= eng.eng_result; key_b_vld <= 1'b1; end
                        endcase
                        state <= ST_IDLE;
                    end
`ifdef ENGINE_TIMEOUT_EN
                    // Abandon the job; result flags stay as they were.
                    else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dh_exchange_sequencer.sv
// Bench for dh_exchange_sequencer: behavioural modexp engine (5-cycle latency, GEN=5) and a job scoreboard
// checked at every eng_start, plus directed checks of results, rejections, stalls and reset.
`timescale 1ns/1ps
module tb_dh_exchange_sequencer;
    localparam int WIDTH       = 8;
    localparam int GEN         = 5;
    localparam int TIMEOUT_CYC = 16;
    localparam int ENG_LAT     = 5;
    localparam int SA          = 6;
    localparam int SB          = 15;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             p_load = 1'b0;
    logic [WIDTH-1:0] p_in   = '0;
    logic             req_a  = 1'b0;
    logic             req_b  = 1'b0;
    logic [WIDTH-1:0] sec_a  = WIDTH'(SA);
    logic [WIDTH-1:0] sec_b  = WIDTH'(SB);
    logic [WIDTH-1:0] pub_a, pub_b, key_a, key_b;
    logic             pub_a_vld, pub_b_vld, key_a_vld, key_b_vld;
    logic             rej, p_err, timeout;
    logic [3:0]       state_o;

    logic             busy_m     = 1'b0;
    logic             busy_force = 1'b0;
    logic             done_m     = 1'b0;
    logic             done_force = 1'b0;
    logic             mute       = 1'b0;
    logic [WIDTH-1:0] result_m   = '0;

    int n_vec  = 0;
    int n_err  = 0;
    int starts = 0;
    int rejs   = 0;
    int cur_p  = 0;

    typedef struct {
        int base;
        int ex;
    } job_t;
    job_t sb_q[$];

    dh_exchange_sequencer_if #(.WIDTH(WIDTH)) eng_if ();

    assign eng_if.eng_busy   = busy_m | busy_force;
    assign eng_if.eng_done   = done_m | done_force;
    assign eng_if.eng_result = result_m;

    dh_exchange_sequencer #(
        .WIDTH(WIDTH), .GEN(GEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .p_load(p_load), .p_in(p_in),
        .req_a(req_a), .req_b(req_b), .sec_a(sec_a), .sec_b(sec_b),
        .eng(eng_if),
        .pub_a(pub_a), .pub_b(pub_b), .key_a(key_a), .key_b(key_b),
        .pub_a_vld(pub_a_vld), .pub_b_vld(pub_b_vld),
        .key_a_vld(key_a_vld), .key_b_vld(key_b_vld),
        .rej(rej), .p_err(p_err), .timeout(timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int modexp(input int b, input int e, input int m);
        int r;
        if (m < 2) return 0;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % m;
        return r;
    endfunction

    task automatic expect_job(input int b, input int e);
        job_t j;
        j.base = b;
        j.ex   = e;
        sb_q.push_back(j);
    endtask

    // Engine model and scoreboard pop, both sampled on the falling edge.
    initial begin : engine_model
        int cnt;
        int ob, oe, om;
        job_t j;
        cnt = 0; ob = 0; oe = 0; om = 0;
        forever begin
            @(negedge clk);
            done_m = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !mute) begin
                    done_m   = 1'b1;
                    result_m = WIDTH'(modexp(ob, oe, om));
                end
            end
            if (eng_if.eng_start) begin
                starts++;
                ob = int'(eng_if.eng_base);
                oe = int'(eng_if.eng_exp);
                om = int'(eng_if.eng_mod);
                if (sb_q.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    j = sb_q.pop_front();
                    check("job_base", ob, j.base);
                    check("job_exp", oe, j.ex);
                    check("job_mod", om, cur_p);
                end
                cnt = ENG_LAT;
            end
            busy_m = (cnt > 0);
            if (rej) rejs++;
        end
    end

    task automatic pulse_req(input logic a, input logic b);
        @(negedge clk); req_a = a; req_b = b;
        @(negedge clk); req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic pload(input int v);
        @(negedge clk); p_in = WIDTH'(v); p_load = 1'b1;
        @(negedge clk); p_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb_q.size() == 0 && state_o == 4'd0 && !busy_m) && n < 200);
        check({tag, "_quiet"}, int'(n < 200), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_state(input int st, input string tag);
        int n;
        n = 0;
        while (int'(state_o) != st && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach"}, int'(state_o), st);
    endtask

    initial begin : global_watchdog
        #200000;
        $display("FAIL global_watchdog: simulation still running at %0t", $time);
        $fatal(1, "bench hung");
    end

    initial begin : stimulus
        int s0, r0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", int'(state_o), 0);
        check("rst_vld", int'({pub_a_vld, pub_b_vld, key_a_vld, key_b_vld}), 0);
        check("rst_pub_a", int'(pub_a), 0);
        check("rst_p_err", int'(p_err), 1);
        check("rst_timeout", int'(timeout), 0);
        check("rst_start_rej", int'({eng_if.eng_start, rej}), 0);
        check("rst_mod", int'(eng_if.eng_mod), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: sequential public keys, then a contended key pair with A priority
        pload(23); cur_p = 23;
        check("t1_p_err", int'(p_err), 0);
        expect_job(GEN, SA);
        pulse_req(1'b1, 1'b0);
        wait_quiet("t1_pa");
        check("t1_pub_a", int'(pub_a), 8);
        check("t1_pub_a_vld", int'(pub_a_vld), 1);
        expect_job(GEN, SB);
        pulse_req(1'b0, 1'b1);
        wait_quiet("t1_pb");
        check("t1_pub_b", int'(pub_b), 19);
        expect_job(19, SA);
        expect_job(8, SB);
        pulse_req(1'b1, 1'b1);
        wait_quiet("t1_keys");
        check("t1_key_a", int'(key_a), 2);
        check("t1_key_b", int'(key_b), 2);
        check("t1_key_vld", int'({key_a_vld, key_b_vld}), 3);
        check("t1_starts", starts, 4);

        // 2: round-robin order from a fresh reset
        do_reset(); cur_p = 0;
        pload(23); cur_p = 23;
        expect_job(GEN, SA);
        expect_job(GEN, SB);
        pulse_req(1'b1, 1'b1);
        wait_quiet("t2_pubs");
        check("t2_pubs", int'({pub_a, pub_b}), (8 << 8) | 19);
        expect_job(8, SB);
        expect_job(19, SA);
        pulse_req(1'b1, 1'b1);
        wait_quiet("t2_keys");
        check("t2_keys", int'({key_a, key_b}), (2 << 8) | 2);

        // 3: Bob's KEY request before Alice's pub is refused
        pload(23);
        check("t3_vld_clear", int'({pub_a_vld, pub_b_vld, key_a_vld, key_b_vld}), 0);
        expect_job(GEN, SB);
        pulse_req(1'b0, 1'b1);
        wait_quiet("t3_pb");
        s0 = starts; r0 = rejs;
        pulse_req(1'b0, 1'b1);
        wait_quiet("t3_rej");
        check("t3_rej_cnt", rejs - r0, 1);
        check("t3_no_start", starts - s0, 0);
        check("t3_pub_b", int'(pub_b), 19);

        // Back-to-back request pulses collapse into one job
        s0 = starts; r0 = rejs;
        expect_job(GEN, SA);
        @(negedge clk); req_a = 1'b1;
        @(negedge clk); @(negedge clk); req_a = 1'b0;
        wait_quiet("t3_absorb");
        check("t3_absorb_starts", starts - s0, 1);
        check("t3_absorb_rej", rejs - r0, 0);

        // p_load and request together: request dropped silently
        s0 = starts; r0 = rejs;
        @(negedge clk); p_in = 8'd23; p_load = 1'b1; req_b = 1'b1;
        @(negedge clk); p_load = 1'b0; req_b = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_pl_req_starts", starts - s0, 0);
        check("t3_pl_req_rej", rejs - r0, 0);
        check("t3_pl_req_vld", int'(pub_a_vld), 0);

        // 4: invalid modulus, boundary 2, p_load refused mid-job
        pload(1);
        check("t4_p_err_1", int'(p_err), 1);
        s0 = starts; r0 = rejs;
        pulse_req(1'b1, 1'b0);
        wait_quiet("t4_perr_req");
        check("t4_perr_rej", rejs - r0, 1);
        check("t4_perr_nostart", starts - s0, 0);
        pload(2);
        check("t4_p_err_2", int'(p_err), 0);
        pload(23); cur_p = 23;
        expect_job(GEN, SA);
        pulse_req(1'b1, 1'b0);
        wait_state(2, "t4_wait");
        r0 = rejs;
        pload(11);
        check("t4_midwait_rej", rejs - r0, 1);
        check("t4_mod_kept", int'(eng_if.eng_mod), 23);
        wait_quiet("t4_job");
        check("t4_pub_a", int'(pub_a), 8);
        check("t4_pub_a_vld", int'(pub_a_vld), 1);
        pload(23);
        check("t4_vld_clear", int'({pub_a_vld, pub_b_vld, key_a_vld, key_b_vld}), 0);

        // 5: engine busy holds the sequencer in ISSUE
        s0 = starts;
        @(negedge clk); busy_force = 1'b1;
        expect_job(GEN, SB);
        pulse_req(1'b0, 1'b1);
        repeat (7) @(negedge clk);
        check("t5_hold_state", int'(state_o), 1);
        check("t5_hold_nostart", starts - s0, 0);
        busy_force = 1'b0;
        @(negedge clk);
        check("t5_start_after_busy", int'(eng_if.eng_start), 1);
        wait_quiet("t5_job");
        check("t5_pub_b", int'(pub_b), 19);

        // Stray done outside WAIT is ignored
        @(negedge clk); done_force = 1'b1;
        @(negedge clk); done_force = 1'b0;
        @(negedge clk);
        check("t5_stray_vld", int'({pub_a_vld, pub_b_vld, key_a_vld, key_b_vld}), 4'b0100);
        check("t5_stray_state", int'(state_o), 0);
        check("t5_timeout_low", int'(timeout), 0);

`ifdef ENGINE_TIMEOUT_EN
        // 6a: watchdog fires after TIMEOUT_CYC cycles in WAIT
        mute = 1'b1;
        expect_job(GEN, SA);
        pulse_req(1'b1, 1'b0);
        wait_state(2, "t6_wait");
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        check("t6_timeout_early", int'(timeout), 0);
        @(negedge clk);
        check("t6_timeout", int'(timeout), 1);
        check("t6_state", int'(state_o), 0);
        check("t6_pub_a_vld", int'(pub_a_vld), 0);
        repeat (ENG_LAT) @(negedge clk);
        mute = 1'b0;
        pload(23);
        check("t6_timeout_clr", int'(timeout), 0);
`endif

        // 6: asynchronous reset mid-WAIT abandons the job
        expect_job(GEN, SA);
        pulse_req(1'b1, 1'b0);
        wait_state(2, "t6_rst_wait");
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_state", int'(state_o), 0);
        check("t6_rst_vld", int'({pub_a_vld, pub_b_vld, key_a_vld, key_b_vld}), 0);
        check("t6_rst_pub_b", int'(pub_b), 0);
        check("t6_rst_ops", int'({eng_if.eng_start, eng_if.eng_base, eng_if.eng_exp, eng_if.eng_mod}), 0);
        check("t6_rst_flags", int'({rej, timeout}), 0);
        check("t6_rst_p_err", int'(p_err), 1);
        repeat (ENG_LAT + 3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_post_vld", int'(pub_a_vld), 0);
        check("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
